// File: rtl/signed_divider_pkg.sv
// signed_divider_pkg
//   Shared definitions for the signed divider: default operand widths, the
//   controller state encoding and a helper that sizes the step counter.
//   The state encoding is the same one the matching 7x7 signed multiplier
//   uses, so one harness can drive either block.
package signed_divider_pkg;

  localparam int DEF_DW = 14;  // dividend / quotient / product width
  localparam int DEF_VW = 7;   // divisor / remainder / operand width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIX    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bits needed for a down-counter that starts at n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/signed_divider_if.sv
// signed_divider_if
//   start/done request bus of the signed divider.
//   master: drives start, dividend, divisor; observes the result.
//   slave : the divider; drives quotient, remainder, done, div_by_zero,
//           overflow.
interface signed_divider_if
  import signed_divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          done;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, div_by_zero, overflow
  );

endinterface

// File: rtl/signed_divider_div_step.sv
// signed_divider_div_step
//   One combinational restoring-division iteration on magnitudes.
//   rem_in  : partial remainder (VW+1 bits, always < dvs_mag)
//   bit_in  : next dividend magnitude bit, MSB first
//   dvs_mag : |divisor|
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this step
module signed_divider_div_step
  import signed_divider_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] dvs_mag,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] dvs_ext;
  logic [VW+1:0] diff;

  // Since rem_in < dvs_mag, the shifted value is < 2*dvs_mag, so the
  // trial difference always fits and its MSB is a valid sign bit.
  assign shifted = {rem_in, bit_in};
  assign dvs_ext = {2'b00, dvs_mag};
  assign diff    = shifted - dvs_ext;
  assign q_bit   = ~diff[VW+1];
  assign rem_out = q_bit ? diff[VW:0] : shifted[VW:0];

endmodule

// File: rtl/signed_divider.sv
// signed_divider
//   Sequential restoring signed divider (inverse of the 7x7 signed
//   multiplier). Divides a DW-bit two's-complement dividend by a VW-bit
//   divisor; quotient truncates toward zero, remainder takes the sign of
//   the dividend. Result after DW+1 edges; divide-by-zero after one edge.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : slave side of signed_divider_if (start/operands in,
//           quotient/remainder/done/div_by_zero/overflow out)
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic           clock,
  input  logic           reset,
  signed_divider_if.slave bus
);

  localparam int            CW       = cnt_width(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [DW-1:0] Q_MIN    = {1'b1, {(DW-1){1'b0}}};

  state_t        state_reg, state_next;
  logic [DW-1:0] dq_reg, dq_next;        // dividend magnitude in, quotient magnitude out
  logic [VW:0]   rem_reg, rem_next;      // partial remainder magnitude
  logic [VW-1:0] dvs_reg, dvs_next;      // |divisor|
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          sign_q_reg, sign_q_next;
  logic          sign_r_reg, sign_r_next;
  logic [DW-1:0] quotient_reg, quotient_next;
  logic [VW-1:0] remainder_reg, remainder_next;
  logic          done_reg, done_next;
  logic          dbz_reg, dbz_next;
  logic          ovf_reg, ovf_next;

  logic [VW:0]   step_rem;
  logic          step_q;

  signed_divider_div_step #(.VW(VW)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dq_reg[DW-1]),
    .dvs_mag (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      dq_reg        <= '0;
      rem_reg       <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dq_reg        <= dq_next;
      rem_reg       <= rem_next;
      dvs_reg       <= dvs_next;
      cnt_reg       <= cnt_next;
      sign_q_reg    <= sign_q_next;
      sign_r_reg    <= sign_r_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      done_reg      <= done_next;
      dbz_reg       <= dbz_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    dq_next        = dq_reg;
    rem_next       = rem_reg;
    dvs_next       = dvs_reg;
    cnt_next       = cnt_reg;
    sign_q_next    = sign_q_reg;
    sign_r_next    = sign_r_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    done_next      = done_reg;
    dbz_next       = dbz_reg;
    ovf_next       = ovf_reg;

    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          done_next = 1'b0;
          dbz_next  = 1'b0;
          ovf_next  = 1'b0;
          if (bus.divisor == '0) begin
            // Zero divisor short-circuits straight to a flagged result.
            quotient_next  = '0;
            remainder_next = '0;
            done_next      = 1'b1;
            dbz_next       = 1'b1;
            state_next     = ST_DONE;
          end else begin
            // Magnitudes are unsigned, so the most negative dividend
            // becomes 2^(DW-1) without loss.
            dq_next     = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
            dvs_next    = bus.divisor[VW-1] ? -bus.divisor : bus.divisor;
            rem_next    = '0;
            sign_q_next = bus.dividend[DW-1] ^ bus.divisor[VW-1];
            sign_r_next = bus.dividend[DW-1];
            cnt_next    = CNT_LAST;
            state_next  = ST_DIVIDE;
          end
        end
      end

      ST_DIVIDE: begin
        // Dividend bits leave at the top while quotient bits enter at
        // the bottom, so after DW steps dq holds the quotient magnitude.
        dq_next  = {dq_reg[DW-2:0], step_q};
        rem_next = step_rem;
        if (cnt_reg == '0) begin
          state_next = ST_FIX;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_FIX: begin
        quotient_next  = sign_q_reg ? -dq_reg : dq_reg;
        remainder_next = sign_r_reg ? -rem_reg[VW-1:0] : rem_reg[VW-1:0];
        // A positive quotient of 2^(DW-1) is unrepresentable; the wrapped
        // pattern is left on quotient and flagged.
        ovf_next       = (dq_reg == Q_MIN) && !sign_q_reg;
        done_next      = 1'b1;
        state_next     = ST_DONE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;

endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider
//   Scoreboard bench: the stimulus process pushes the expected result of
//   every accepted request; an independent monitor pops and compares
//   whenever done is presented after that request's accepting edge.
module tb_signed_divider;
  import signed_divider_pkg::*;

  localparam int DW      = 14;
  localparam int VW      = 7;
  localparam int LAT_DIV = DW + 1;  // edges from accepting edge to done
  localparam int LAT_DBZ = 0;       // done set on the accepting edge itself

  typedef struct {
    int            dvd;
    int            dvs;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            lat;
    int            accept;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  exp_t sb[$];
  exp_t mon_e;

  signed_divider_if #(.DW(DW), .VW(VW)) bus ();

  signed_divider #(.DW(DW), .VW(VW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares the head of the scoreboard when a result appears.
  initial forever begin
    @(negedge clock);
    if (reset && sb.size() > 0 && bus.done && cyc >= sb[0].accept) begin
      mon_e = sb.pop_front();
      n_txn++;
      check("latency",     32'(cyc - mon_e.accept), 32'(mon_e.lat));
      check("quotient",    32'(bus.quotient),       32'(mon_e.q));
      check("remainder",   32'(bus.remainder),      32'(mon_e.r));
      check("div_by_zero", 32'(bus.div_by_zero),    32'(mon_e.dbz));
      check("overflow",    32'(bus.overflow),       32'(mon_e.ovf));
      $display("[TB] txn %0d: %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d",
               n_txn, mon_e.dvd, mon_e.dvs, $signed(bus.quotient),
               $signed(bus.remainder), bus.div_by_zero, bus.overflow,
               cyc - mon_e.accept);
    end
  end

  // Returns just after a falling edge once every pushed result is checked.
  task automatic wait_idle();
    int budget = 0;
    @(negedge clock);
    while (sb.size() > 0 && budget < 60) begin
      @(negedge clock);
      budget++;
    end
    if (sb.size() > 0) begin
      check("result_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input int dvd, input int dvs, input int q, input int r,
                       input logic dbz, input logic ovf);
    exp_t e;
    wait_idle();
    e.dvd    = dvd;
    e.dvs    = dvs;
    e.q      = DW'(q);
    e.r      = VW'(r);
    e.dbz    = dbz;
    e.ovf    = ovf;
    e.lat    = dbz ? LAT_DBZ : LAT_DIV;
    e.accept = cyc + 1;
    bus.dividend = DW'(dvd);
    bus.divisor  = VW'(dvs);
    bus.start    = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    bus.start    = 1'b0;
    // Operands are don't-care after the accepting edge.
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_quotient"},    32'(bus.quotient),    32'd0);
    check({tag, "_remainder"},   32'(bus.remainder),   32'd0);
    check({tag, "_done"},        32'(bus.done),        32'd0);
    check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    check({tag, "_overflow"},    32'(bus.overflow),    32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_list[8] = '{-64, -63, -17, -1, 0, 1, 29, 63};
    int done_seen;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset        = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    // Directed vectors: dividend, divisor, quotient, remainder, dbz, ovf.
    issue(   40,  -8,    -5,  0, 1'b0, 1'b0);
    issue(  -41,   8,    -5, -1, 1'b0, 1'b0);
    issue(   10, -11,     0, 10, 1'b0, 1'b0);
    issue(-8192,  -1, 8192,   0, 1'b0, 1'b1);
    issue(    1,   1,     1,  0, 1'b0, 1'b0);
    issue(    5,   0,     0,  0, 1'b1, 1'b0);
    issue(   -7,   0,     0,  0, 1'b1, 1'b0);
    issue(-8192,   1, -8192,  0, 1'b0, 1'b0);
    issue( 8191, -64,  -127, 63, 1'b0, 1'b0);
    issue( -100,   7,   -14, -2, 1'b0, 1'b0);
    issue(  127, -64,    -1, 63, 1'b0, 1'b0);
    issue(    3,  -5,     0,  3, 1'b0, 1'b0);
    issue( 8191,  63,   130,  1, 1'b0, 1'b0);
    issue(  100,   7,    14,  2, 1'b0, 1'b0);
    wait_idle();

    // Abort a run with reset while in DIVIDE; nothing partial may appear.
    bus.dividend = DW'(-41);
    bus.divisor  = VW'(8);
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (6) @(negedge clock);
    check("busy_before_abort", 32'(bus.done), 32'd0);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done) done_seen++;
    end
    check("no_partial_result", 32'(done_seen), 32'd0);

    // Fresh run; a second start mid-DIVIDE must be ignored.
    issue(-8, 1, -8, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    bus.dividend = DW'(100);
    bus.divisor  = VW'(3);
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_idle();

    // Round trip: multiplier product A*B divided by B returns A exactly.
    for (int ai = 0; ai < 8; ai++) begin
      for (int b = -64; b <= 63; b++) begin
        if (b != 0) issue(a_list[ai] * b, b, a_list[ai], 0, 1'b0, 1'b0);
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
